// File: rtl/spi_slave_tx.sv
// SPI mode-0 slave transmitter: one holding byte feeding an MSB-first shift register,
// with SCK/CS synchronised into the clk domain and a lockout for transactions already in progress at reset.
module spi_slave_tx #(
   parameter logic [7:0]  IDLE_BYTE   = 8'hFF,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] iTxData,
   input  logic       iTxValid,
   output logic       oTxReady,
   output logic       oTxDone,
   output logic       oUnderrun,
   input  logic       iSPIClk,
   input  logic       iSPICS,
   output logic       oMISO,
   output logic       oMISOEn
);

   typedef enum logic [1:0] {IDLE, ACTIVE, LOCKOUT} state_t;

   localparam logic [1:0] SETTLE_CNT = 2'(SYNC_STAGES);

   state_t                 state;
   logic [SYNC_STAGES-1:0] sck_sync;
   logic [SYNC_STAGES-1:0] cs_sync;
   logic                   sck_d;
   logic                   cs_d;
   logic                   sck_s;
   logic                   cs_s;
   logic                   sck_rise;
   logic                   sck_fall;
   logic                   cs_rise;
   logic                   cs_fall;
   logic [7:0]             hold;
   logic                   hold_full;
   logic [7:0]             shift;
   logic [2:0]             bit_cnt;
   logic                   reload;
   logic [1:0]             settle;
   logic                   accept;
   logic                   load_now;

   always_ff @(posedge clk) begin
      if (reset) begin
         sck_sync <= '0;
         cs_sync  <= '1;
         sck_d    <= 1'b0;
         cs_d     <= 1'b1;
      end else begin
         sck_sync <= {sck_sync[SYNC_STAGES-2:0], iSPIClk};
         cs_sync  <= {cs_sync[SYNC_STAGES-2:0], iSPICS};
         sck_d    <= sck_s;
         cs_d     <= cs_s;
      end
   end

   assign sck_s    = sck_sync[SYNC_STAGES-1];
   assign cs_s     = cs_sync[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_d;
   assign sck_fall = ~sck_s & sck_d;
   assign cs_rise  = cs_s & ~cs_d;
   assign cs_fall  = ~cs_s & cs_d;

   assign oTxReady = ~hold_full;
   assign accept   = iTxValid & ~hold_full;
   // CS rise outranks a coincident SCK fall, so a byte boundary at end of transaction never reloads
   assign load_now = ((state == IDLE) && cs_fall) ||
                     ((state == ACTIVE) && !cs_rise && sck_fall && reload);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= LOCKOUT;
         hold      <= '0;
         hold_full <= 1'b0;
         shift     <= IDLE_BYTE;
         bit_cnt   <= '0;
         reload    <= 1'b0;
         settle    <= '0;
         oTxDone   <= 1'b0;
         oUnderrun <= 1'b0;
      end else begin
         oTxDone   <= 1'b0;
         oUnderrun <= 1'b0;
         if (accept) begin
            hold      <= iTxData;
            hold_full <= 1'b1;
         end
         if (load_now) begin
            if (hold_full) begin
               shift     <= hold;
               hold_full <= 1'b0;
            end else begin
               shift     <= IDLE_BYTE;
               oUnderrun <= 1'b1;
            end
         end
         case (state)
            // Wait for the synchronizer to flush its reset value before trusting CS
            LOCKOUT: begin
               if (settle != SETTLE_CNT) settle <= settle + 2'd1;
               else if (cs_s)            state  <= IDLE;
            end
            IDLE: begin
               if (cs_fall) begin
                  state   <= ACTIVE;
                  bit_cnt <= '0;
                  reload  <= 1'b0;
               end
            end
            ACTIVE: begin
               if (cs_rise) begin
                  state   <= IDLE;
                  shift   <= IDLE_BYTE;
                  bit_cnt <= '0;
                  reload  <= 1'b0;
               end else if (sck_rise) begin
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     oTxDone <= 1'b1;
                     reload  <= 1'b1;
                  end
               end else if (sck_fall) begin
                  if (reload) reload <= 1'b0;
                  else        shift  <= {shift[6:0], 1'b0};
               end
            end
            default: state <= LOCKOUT;
         endcase
      end
   end

   assign oMISO   = (state == ACTIVE) ? shift[7] : 1'b1;
   assign oMISOEn = (state == ACTIVE);

endmodule

// File: tb/tb_spi_slave_tx.sv
// Bench for spi_slave_tx: a mode-0 master at clk/8 with a byte-queue model of what the slave
// must shift out, a per-cycle monitor for MISO enable/idle level and pulse counts, and literal byte checks.
module tb_spi_slave_tx;

   localparam logic [7:0]  IDLE = 8'hFF;
   localparam int unsigned SYNC = 2;

   logic       clk      = 1'b0;
   logic       reset    = 1'b1;
   logic [7:0] tx_data  = '0;
   logic       tx_valid = 1'b0;
   logic       sck      = 1'b0;
   logic       cs       = 1'b1;
   logic       tx_ready;
   logic       tx_done;
   logic       underrun;
   logic       miso;
   logic       miso_en;

   always #5 clk = ~clk;

   spi_slave_tx #(
      .IDLE_BYTE   (IDLE),
      .SYNC_STAGES (SYNC)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .iTxData   (tx_data),
      .iTxValid  (tx_valid),
      .oTxReady  (tx_ready),
      .oTxDone   (tx_done),
      .oUnderrun (underrun),
      .iSPIClk   (sck),
      .iSPICS    (cs),
      .oMISO     (miso),
      .oMISOEn   (miso_en)
   );

   int         tests = 0;
   int         fails = 0;
   logic [7:0] exp_q[$];
   logic [7:0] rx_q[$];
   logic [7:0] cur_byte = '0;
   logic [7:0] got = '0;
   int         bit_idx = 0;
   bit         reload_m = 1'b0;
   bit         lockout_m = 1'b0;
   int         exp_done = 0;
   int         exp_under = 0;
   int         obs_done = 0;
   int         obs_under = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Next byte the slave must send: queued data, or the idle byte with an underrun
   task automatic pop_or_idle(output logic [7:0] b);
      if (exp_q.size() == 0) begin
         b = IDLE;
         exp_under++;
      end else begin
         b = exp_q.pop_front();
      end
   endtask

   task automatic write_byte(input logic [7:0] b);
      bit done = 1'b0;
      int n    = 0;
      @(negedge clk);
      tx_data  = b;
      tx_valid = 1'b1;
      while (!done && n < 400) begin
         if (tx_ready === 1'b1) begin
            exp_q.push_back(b);
            done = 1'b1;
         end
         @(negedge clk);
         n++;
      end
      tx_valid = 1'b0;
      if (!done) chk("write_timeout", 32'd0, 32'd1);
   endtask

   task automatic sck_rise();
      repeat (4) @(negedge clk);
      if (!lockout_m) begin
         chk("miso_bit", 32'(miso), 32'(cur_byte[7-bit_idx]));
         got = {got[6:0], miso};
         bit_idx++;
         if (bit_idx == 8) begin
            rx_q.push_back(got);
            exp_done++;
            reload_m = 1'b1;
            bit_idx  = 0;
         end
      end
      sck = 1'b1;
   endtask

   task automatic sck_fall();
      repeat (4) @(negedge clk);
      sck = 1'b0;
      if (!lockout_m && reload_m) begin
         pop_or_idle(cur_byte);
         reload_m = 1'b0;
      end
   endtask

   // Last SCK fall and CS rise together: the slave must not reload past the final byte
   task automatic end_txn();
      repeat (4) @(negedge clk);
      sck       = 1'b0;
      cs        = 1'b1;
      reload_m  = 1'b0;
      bit_idx   = 0;
      lockout_m = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic cs_low();
      @(negedge clk);
      cs = 1'b0;
      if (!lockout_m) begin
         pop_or_idle(cur_byte);
         bit_idx  = 0;
         reload_m = 1'b0;
      end
      repeat (6) @(negedge clk);
   endtask

   task automatic xfer(input int nbits, input int wr_at, input logic [7:0] wr_byte);
      for (int i = 0; i < nbits; i++) begin
         sck_rise();
         if (i < nbits - 1) sck_fall();
         if (i == wr_at) write_byte(wr_byte);
      end
      end_txn();
   endtask

   task automatic check_ready(input string name);
      chk(name, 32'(tx_ready), 32'(exp_q.size() == 0));
   endtask

   task automatic check_counts(input int lit_done, input int lit_under);
      repeat (6) @(negedge clk);
      chk("done_count", 32'(obs_done), 32'(exp_done));
      chk("underrun_count", 32'(obs_under), 32'(exp_under));
      chk("done_literal", 32'(obs_done), 32'(lit_done));
      chk("underrun_literal", 32'(obs_under), 32'(lit_under));
   endtask

   task automatic expect_rx(input string name, input logic [7:0] b);
      logic [31:0] v;
      v = (rx_q.size() != 0) ? 32'(rx_q.pop_front()) : 32'h100;
      chk(name, v, 32'(b));
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset     = 1'b1;
      lockout_m = !cs;
      exp_q.delete();
      reload_m  = 1'b0;
      bit_idx   = 0;
      repeat (3) @(negedge clk);
      chk("rst_miso", 32'(miso), 32'd1);
      chk("rst_miso_en", 32'(miso_en), 32'd0);
      chk("rst_ready", 32'(tx_ready), 32'd1);
      chk("rst_done", 32'(tx_done), 32'd0);
      chk("rst_underrun", 32'(underrun), 32'd0);
      reset = 1'b0;
   endtask

   initial begin
      fork
         begin : monitor
            int   cs_stable;
            logic cs_prev;
            cs_stable = 0;
            cs_prev   = 1'b1;
            forever begin
               @(negedge clk);
               if (reset) begin
                  cs_stable = 0;
                  cs_prev   = cs;
               end else begin
                  if (cs !== cs_prev)       cs_stable = 0;
                  else if (cs_stable < 1000) cs_stable++;
                  cs_prev = cs;
                  if (tx_done === 1'b1)  obs_done++;
                  if (underrun === 1'b1) obs_under++;
                  if (cs_stable >= 5) begin
                     chk("miso_en", 32'(miso_en), 32'(!cs && !lockout_m));
                     if (cs || lockout_m) chk("miso_idle", 32'(miso), 32'd1);
                  end
               end
            end
         end
      join_none

      do_reset();
      repeat (10) @(negedge clk);

      // A5, single byte
      write_byte(8'hA5);
      check_ready("ready_full_a5");
      cs_low();
      check_ready("ready_after_load");
      chk("ready_after_load_lit", 32'(tx_ready), 32'd1);
      xfer(8, -1, 8'h00);
      expect_rx("rx_a5", 8'hA5);
      check_counts(1, 0);

      // 3C then C3 queued mid-byte
      write_byte(8'h3C);
      cs_low();
      xfer(16, 2, 8'hC3);
      expect_rx("rx_3c", 8'h3C);
      expect_rx("rx_c3", 8'hC3);
      check_counts(3, 0);

      // Empty holding register: idle byte and one underrun
      check_ready("ready_empty");
      cs_low();
      xfer(8, -1, 8'h00);
      expect_rx("rx_idle", 8'hFF);
      check_counts(4, 1);

      // Aborted byte after 4 bits, then a fresh transaction
      write_byte(8'h81);
      cs_low();
      xfer(4, -1, 8'h00);
      chk("partial_81", 32'(got[3:0]), 32'h8);
      check_counts(4, 1);
      write_byte(8'h42);
      cs_low();
      xfer(8, -1, 8'h00);
      expect_rx("rx_42", 8'h42);
      check_counts(5, 1);

      // Reset mid-transaction with a byte held; CS stays low through reset
      write_byte(8'h99);
      cs_low();
      write_byte(8'h77);
      for (int i = 0; i < 3; i++) begin
         sck_rise();
         sck_fall();
      end
      do_reset();
      repeat (8) @(negedge clk);
      check_ready("ready_after_reset");
      xfer(8, -1, 8'h00);
      check_counts(5, 1);
      write_byte(8'h5A);
      cs_low();
      xfer(8, -1, 8'h00);
      expect_rx("rx_5a", 8'h5A);
      check_counts(6, 1);

      // Second write held off while holding is full
      write_byte(8'h11);
      fork
         write_byte(8'h22);
         begin
            repeat (6) begin
               @(negedge clk);
               check_ready("ready_when_full");
            end
            cs_low();
            xfer(16, -1, 8'h00);
         end
      join
      expect_rx("rx_11", 8'h11);
      expect_rx("rx_22", 8'h22);
      check_counts(8, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      repeat (20000) @(posedge clk);
      $display("FAIL watchdog: run did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/spi_slave_tx.md
SPI_SLAVE_TX -- requirements
Module: spi_slave_tx

Interface
REQ-001 SHALL have parameter IDLE_BYTE, default 8'hFF: byte shifted out when no data is queued.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on iSPIClk and iSPICS, legal range 2..3.
REQ-003 SHALL have port clk, input, 1: system clock (WF_CLK at top level); all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port iTxData, input, 8: byte to transmit, MSB first.
REQ-006 SHALL have port iTxValid, input, 1: iTxData valid this cycle.
REQ-007 SHALL have port oTxReady, output, 1: holding register empty; write accepted when iTxValid && oTxReady.
REQ-008 SHALL have port oTxDone, output, 1: one-clk pulse when the 8th bit of a byte has been sampled by the master.
REQ-009 SHALL have port oUnderrun, output, 1: one-clk pulse when IDLE_BYTE is substituted for missing data.
REQ-010 SHALL have port iSPIClk, input, 1: asynchronous SPI SCK, mode 0 (CPOL=0, CPHA=0).
REQ-011 SHALL have port iSPICS, input, 1: asynchronous chip select, active low.
REQ-012 SHALL have port oMISO, output, 1: serial data to master.
REQ-013 SHALL have port oMISOEn, output, 1: MISO output enable for the top-level tristate.

Function
REQ-014 SHALL pass iSPIClk and iSPICS through SYNC_STAGES flops, then one edge-detect flop; SCK rise/fall and CS fall/rise SHALL each be one-clk pulses.
REQ-015 SHALL operate correctly for SCK frequency <= clk/8; faster SCK is unsupported and unchecked.
REQ-016 SHALL keep a 1-byte holding register plus an 8-bit shift register and a 3-bit bit counter.
REQ-017 oTxReady SHALL equal !holdFull (combinational); an accepted write SHALL set holdFull on the next clk.
REQ-018 SHALL implement states IDLE (CS high), ACTIVE (CS low, shifting), LOCKOUT (CS was low at reset release).
REQ-019 IDLE -> ACTIVE on the CS-fall pulse: load shift from holding (clear holdFull), or load IDLE_BYTE and pulse oUnderrun if holding is empty; bit counter = 0.
REQ-020 In ACTIVE, SCK rise SHALL increment the bit counter; when incrementing from 7, it SHALL pulse oTxDone, wrap the counter to 0 and set a reload flag.
REQ-021 In ACTIVE, SCK fall SHALL shift left by one, or, when the reload flag is set, load the next byte by the REQ-019 rule and clear the flag.
REQ-022 oMISO SHALL equal shift[7] in ACTIVE and 1 otherwise; oMISOEn SHALL be 1 only in ACTIVE.
REQ-023 Latency: oMISO SHALL update SYNC_STAGES+1 clks after the physical SCK/CS edge.
REQ-024 A CS-rise pulse in ACTIVE SHALL go to IDLE, discard the partial shift byte, clear the reload flag and counter, and produce no oTxDone; the holding register is untouched.
REQ-025 A write accepted in the same clk as a load from an empty holding register SHALL land in holding (oUnderrun still pulses); it is not used for the current byte.
REQ-026 A write SHALL never overwrite a full holding register; iTxValid with oTxReady low SHALL be ignored.
REQ-027 CS fall and CS rise SHALL never be seen in the same clk (guaranteed by the synchronizer); SCK edges in IDLE and LOCKOUT SHALL be ignored.

Reset
REQ-028 On reset: oMISO=1, oMISOEn=0, oTxReady=1, oTxDone=0, oUnderrun=0, shift=IDLE_BYTE, counter=0, reload=0, synchronizer flops=1 (CS) and 0 (SCK).
REQ-029 After reset, the state SHALL be LOCKOUT if synced CS is low, else IDLE; LOCKOUT -> IDLE on CS high, so a transaction in progress at reset is never joined mid-byte.
REQ-030 A reset asserted mid-transaction SHALL drop the in-flight byte and the holding byte.

Verification
REQ-031 Write 8'hA5, CS low, 8 SCK cycles at clk/8 -> master samples 1,0,1,0,0,1,0,1; exactly one oTxDone; oTxReady=1 after load.
REQ-032 Write 8'h3C then 8'hC3 queued during byte 1, 16 SCKs -> master receives 3C, C3; two oTxDone; no oUnderrun.
REQ-033 CS low with holding empty, 8 SCKs -> master receives FF; oUnderrun once at CS fall; oTxDone once.
REQ-034 Write 8'h81, CS high after 4 SCKs, write 8'h42, new transaction -> first transaction gives 1,0,0,0; no oTxDone; second transaction shifts 42.
REQ-035 Reset with CS held low, 8 SCKs -> oMISOEn stays 0, no pulses; CS high then low with 8'h5A queued -> master receives 5A.
REQ-036 iTxValid held with holding full (write 11, then 22 while full) -> 22 rejected until oTxReady=1; master receives 11 then 22.
